// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkg
// Brief    : Shared FSM state encoding and header field layout for the
//            packet flow controller.
// Revision : 1.0 - initial release
// ============================================================================
package router_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        PARITY  = 2'd2,
        DROP    = 2'd3
    } state_t;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;
    localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;

    localparam logic [1:0] ADDR_ILLEGAL = 2'b11;

endpackage : router_pkg
`default_nettype wire

// File: rtl/chan_occupancy.sv
`default_nettype none
// ============================================================================
// Module   : chan_occupancy
// Brief    : Occupancy counter for one output channel FIFO with a registered
//            non-empty flag.
// Revision : 1.0 - initial release
// ============================================================================
module chan_occupancy #(
    parameter int FIFO_DEPTH = 16,
    parameter int OCC_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             read_enb,
    output logic             vld_chan,
    output logic [OCC_W-1:0] occupancy
);

    localparam logic [OCC_W-1:0] c_occ_full = OCC_W'(FIFO_DEPTH);

    logic [OCC_W-1:0] r_count;
    logic [OCC_W-1:0] w_count_next;
    logic             r_vld;
    logic             w_rd_eff;

    assign w_rd_eff = read_enb && (r_count != '0);

    always_comb begin
        w_count_next = r_count;
        if (wr_en && !w_rd_eff && (r_count != c_occ_full)) begin
            w_count_next = r_count + OCC_W'(1);
        end else if (!wr_en && w_rd_eff) begin
            w_count_next = r_count - OCC_W'(1);
        end
    end

    // The flag is computed from the next count so it is a pure flop output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_vld   <= (w_count_next != '0);
        end
    end

    assign occupancy = r_count;
    assign vld_chan  = r_vld;

endmodule : chan_occupancy
`default_nettype wire

// File: rtl/pkt_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pkt_flow_ctrl
// Brief    : Packet router front end: header decode, per-channel write strobes,
//            back-pressure and occupancy tracking for three channel FIFOs.
//            Optional parity checking is enabled by defining
//            PKT_PARITY_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_flow_ctrl
    import router_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       packet_valid,
    output logic       suspend_data_in,
    output logic       err,
    output logic       wr_en_0,
    output logic       wr_en_1,
    output logic       wr_en_2,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    output logic       vld_chan_0,
    output logic       vld_chan_1,
    output logic       vld_chan_2
);

    localparam int               OCC_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0] c_occ_full = OCC_W'(FIFO_DEPTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_addr;
    logic [1:0]       w_addr_next;
    logic [6:0]       r_remaining;
    logic [6:0]       w_remaining_next;

    logic [LEN_W-1:0] w_len;
    logic [1:0]       w_hdr_addr;
    logic [1:0]       w_target;
    logic [3:0]       w_full_vec;
    logic             w_suspend;
    logic             w_accept;
    logic             w_write;
    logic [2:0]       w_wr;
    logic [2:0]       w_rd;
    logic [2:0]       w_vld;
    logic [OCC_W-1:0] w_occ [3];

    assign w_len      = data[LEN_MSB:LEN_LSB];
    assign w_hdr_addr = data[ADDR_MSB:ADDR_LSB];
    assign w_target   = (r_state == IDLE) ? w_hdr_addr : r_addr;

    // Bit 3 stands for the illegal address, which never back-pressures.
    assign w_full_vec = {1'b0,
                         (w_occ[2] == c_occ_full),
                         (w_occ[1] == c_occ_full),
                         (w_occ[0] == c_occ_full)};

    assign w_suspend = !reset && packet_valid && (r_state != DROP) && w_full_vec[w_target];
    assign w_accept  = !reset && packet_valid && !w_suspend;
    assign w_write   = w_accept && (r_state != DROP) && (w_target != ADDR_ILLEGAL);

    always_comb begin
        w_state_next     = r_state;
        w_addr_next      = r_addr;
        w_remaining_next = r_remaining;
        if (w_accept) begin
            case (r_state)
                IDLE: begin
                    w_addr_next = w_hdr_addr;
                    if (w_hdr_addr == ADDR_ILLEGAL) begin
                        w_remaining_next = {1'b0, w_len} + 7'd1;
                        w_state_next     = DROP;
                    end else begin
                        w_remaining_next = {1'b0, w_len};
                        w_state_next     = (w_len == '0) ? PARITY : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    w_remaining_next = r_remaining - 7'd1;
                    if (r_remaining == 7'd1) begin
                        w_state_next = PARITY;
                    end
                end
                PARITY: begin
                    w_state_next = IDLE;
                end
                DROP: begin
                    w_remaining_next = r_remaining - 7'd1;
                    if (r_remaining == 7'd1) begin
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= 2'b00;
            r_remaining <= 7'd0;
        end else begin
            r_state     <= w_state_next;
            r_addr      <= w_addr_next;
            r_remaining <= w_remaining_next;
        end
    end

`ifdef PKT_PARITY_CHECK_EN
    logic [7:0] r_acc;
    logic       r_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc <= 8'h00;
            r_err <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    IDLE:    r_acc <= data;
                    PAYLOAD: r_acc <= r_acc ^ data;
                    PARITY:  r_err <= (r_acc != data);
                    default: r_acc <= r_acc;
                endcase
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign w_rd = {read_enb_2, read_enb_1, read_enb_0};

    for (genvar i = 0; i < 3; i++) begin : g_chan
        assign w_wr[i] = w_write && (w_target == 2'(i));

        chan_occupancy #(
            .FIFO_DEPTH (FIFO_DEPTH),
            .OCC_W      (OCC_W)
        ) u_occ (
            .clock     (clock),
            .reset     (reset),
            .wr_en     (w_wr[i]),
            .read_enb  (w_rd[i]),
            .vld_chan  (w_vld[i]),
            .occupancy (w_occ[i])
        );
    end

    assign suspend_data_in = w_suspend;
    assign wr_en_0         = w_wr[0];
    assign wr_en_1         = w_wr[1];
    assign wr_en_2         = w_wr[2];
    assign vld_chan_0      = w_vld[0];
    assign vld_chan_1      = w_vld[1];
    assign vld_chan_2      = w_vld[2];

endmodule : pkt_flow_ctrl
`default_nettype wire

// File: tb/tb_pkt_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_flow_ctrl
// Brief    : Self-checking bench for pkt_flow_ctrl with a packet-level model
//            compared every cycle, plus directed literal checkpoints.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_flow_ctrl;

    localparam int DEPTH = 4;
`ifdef PKT_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data = 8'h00;
    logic       packet_valid = 1'b0;
    logic       read_enb_0 = 1'b0;
    logic       read_enb_1 = 1'b0;
    logic       read_enb_2 = 1'b0;
    logic       suspend_data_in;
    logic       err;
    logic       wr_en_0, wr_en_1, wr_en_2;
    logic       vld_chan_0, vld_chan_1, vld_chan_2;

    int n_total = 0;
    int n_pass  = 0;
    int wr1_cnt = 0;
    int wr_any_cnt = 0;
    logic [2:0] last_wr;

    // Packet-level model state
    int         occ [3] = '{0, 0, 0};
    bit         in_pkt = 1'b0;
    int         cur_addr = 0;
    int         left = 0;
    logic [7:0] acc = 8'h00;
    bit         exp_err = 1'b0;

    pkt_flow_ctrl #(.FIFO_DEPTH(DEPTH)) u_dut (
        .clock           (clock),
        .reset           (reset),
        .data            (data),
        .packet_valid    (packet_valid),
        .suspend_data_in (suspend_data_in),
        .err             (err),
        .wr_en_0         (wr_en_0),
        .wr_en_1         (wr_en_1),
        .wr_en_2         (wr_en_2),
        .read_enb_0      (read_enb_0),
        .read_enb_1      (read_enb_1),
        .read_enb_2      (read_enb_2),
        .vld_chan_0      (vld_chan_0),
        .vld_chan_1      (vld_chan_1),
        .vld_chan_2      (vld_chan_2)
    );

    always #5 clock = ~clock;

    function automatic int m_target();
        return in_pkt ? cur_addr : int'(data[1:0]);
    endfunction

    function automatic bit m_full(input int t);
        return (t < 3) && (occ[t] == DEPTH);
    endfunction

    function automatic logic [7:0] m_expect();
        int         t;
        logic [2:0] wr;
        logic       s;
        logic [2:0] v;
        t  = m_target();
        wr = 3'b000;
        s  = 1'b0;
        if (!reset && packet_valid) begin
            if (m_full(t)) s = 1'b1;
            else if (t < 3) wr[t] = 1'b1;
        end
        for (int i = 0; i < 3; i++) v[i] = (occ[i] != 0);
        return {wr, s, exp_err, v};
    endfunction

    task automatic model_step();
        int         t;
        bit         ok;
        logic [2:0] wr;
        logic [2:0] rd;
        t  = m_target();
        ok = packet_valid && !m_full(t);
        wr = 3'b000;
        exp_err = 1'b0;
        if (ok && t < 3) wr[t] = 1'b1;
        rd = {read_enb_2, read_enb_1, read_enb_0};
        if (ok) begin
            if (!in_pkt) begin
                cur_addr = int'(data[1:0]);
                left     = int'(data[7:2]) + 1;
                acc      = data;
                in_pkt   = 1'b1;
            end else begin
                left--;
                if (left == 0) begin
                    in_pkt = 1'b0;
                    if (PAR_EN && cur_addr != 3 && acc != data) exp_err = 1'b1;
                end else begin
                    acc = acc ^ data;
                end
            end
        end
        for (int i = 0; i < 3; i++)
            occ[i] = occ[i] + int'(wr[i]) - ((rd[i] && occ[i] > 0) ? 1 : 0);
    endtask

    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            in_pkt = 1'b0; cur_addr = 0; left = 0; acc = 8'h00; exp_err = 1'b0;
            for (int i = 0; i < 3; i++) occ[i] = 0;
        end else begin
            model_step();
        end
    end

    initial forever begin
        logic [7:0] act, exp;
        @(negedge clock);
        act = {wr_en_2, wr_en_1, wr_en_0, suspend_data_in, err, vld_chan_2, vld_chan_1, vld_chan_0};
        exp = m_expect();
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL cycle_outputs t=%0t {wr,susp,err,vld} got %b expected %b", $time, act, exp);
        if (wr_en_1) wr1_cnt++;
        if (wr_en_0 || wr_en_1 || wr_en_2) wr_any_cnt++;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int budget;
        budget = 40;
        data = b;
        packet_valid = 1'b1;
        @(negedge clock);
        while (suspend_data_in && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (budget == 0) begin
            n_total++;
            $display("FAIL send_timeout: byte %h suspended=%b required accepted", b, suspend_data_in);
        end
        last_wr = {wr_en_2, wr_en_1, wr_en_0};
        tick();
        packet_valid = 1'b0;
    endtask

    task automatic read_pulse(input int ch, input int n);
        repeat (n) begin
            case (ch)
                0: read_enb_0 = 1'b1;
                1: read_enb_1 = 1'b1;
                default: read_enb_2 = 1'b1;
            endcase
            tick();
            read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        data = 8'h01;
        packet_valid = 1'b1;
        @(negedge clock);
        check("reset_outputs", {wr_en_2, wr_en_1, wr_en_0, suspend_data_in, err, vld_chan_2, vld_chan_1, vld_chan_0}, 8'h00);
        tick();
        reset = 1'b0;
        packet_valid = 1'b0;
        tick();

        // Good packet to channel 1 with a mid-packet stall
        wr1_cnt = 0;
        send_byte(8'h09);
        repeat (2) tick();
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'h90);
        @(negedge clock);
        check("good_pkt_vld1", {7'd0, vld_chan_1}, 8'h01);
        check("good_pkt_err", {7'd0, err}, 8'h00);
        check("good_pkt_wr1_count", 8'(wr1_cnt), 8'd4);
        tick();
        read_pulse(1, 3);
        @(negedge clock);
        check("drain1_partial_vld", {7'd0, vld_chan_1}, 8'h01);
        tick();
        read_pulse(1, 1);
        @(negedge clock);
        check("drain1_vld", {7'd0, vld_chan_1}, 8'h00);
        tick();

        // Bad parity packet
        send_byte(8'h09);
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'h91);
        @(negedge clock);
        check("bad_parity_err", {7'd0, err}, {7'd0, PAR_EN});
        @(negedge clock);
        check("bad_parity_err_one_cycle", {7'd0, err}, 8'h00);
        tick();
        read_pulse(1, 4);

        // Illegal address drop, then a normal packet
        wr_any_cnt = 0;
        send_byte(8'h0B);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        @(negedge clock);
        check("drop_no_wr", 8'(wr_any_cnt), 8'd0);
        tick();
        send_byte(8'h04);
        check("after_drop_header_wr", {5'd0, last_wr}, 8'h01);
        send_byte(8'h55);
        send_byte(8'h51);

        // Channel 0 at 3; header fills it to DEPTH, parity byte must stall
        send_byte(8'h00);
        data = 8'h00;
        packet_valid = 1'b1;
        @(negedge clock);
        check("full_suspend", {7'd0, suspend_data_in}, 8'h01);
        check("full_no_wr0", {7'd0, wr_en_0}, 8'h00);
        tick();
        @(negedge clock);
        check("full_suspend_hold", {7'd0, suspend_data_in}, 8'h01);
        tick();
        read_enb_0 = 1'b1;
        @(negedge clock);
        check("full_suspend_during_read", {7'd0, suspend_data_in}, 8'h01);
        tick();
        read_enb_0 = 1'b0;
        @(negedge clock);
        check("resume_suspend", {7'd0, suspend_data_in}, 8'h00);
        check("resume_wr0", {7'd0, wr_en_0}, 8'h01);
        tick();
        packet_valid = 1'b0;
        read_pulse(0, 4);
        @(negedge clock);
        check("drain0_vld", {7'd0, vld_chan_0}, 8'h00);
        tick();

        // Simultaneous write and read on channel 2 at occupancy 3
        send_byte(8'h06);
        send_byte(8'h77);
        send_byte(8'h71);
        read_enb_2 = 1'b1;
        send_byte(8'h02);
        read_enb_2 = 1'b0;
        send_byte(8'h02);
        data = 8'h02;
        packet_valid = 1'b1;
        @(negedge clock);
        check("hold_then_full_suspend", {7'd0, suspend_data_in}, 8'h01);
        tick();
        packet_valid = 1'b0;
        read_pulse(2, 3);
        @(negedge clock);
        check("drain2_3_vld", {7'd0, vld_chan_2}, 8'h01);
        tick();
        read_pulse(2, 3);
        @(negedge clock);
        check("drain2_empty_vld", {7'd0, vld_chan_2}, 8'h00);
        tick();
        send_byte(8'h02);
        send_byte(8'h02);
        read_pulse(2, 1);
        @(negedge clock);
        check("empty_read_ignored_vld", {7'd0, vld_chan_2}, 8'h01);
        tick();
        read_pulse(2, 1);

        // Reset in the middle of a channel-0 packet
        send_byte(8'h14);
        send_byte(8'hAA);
        data = 8'hBB;
        packet_valid = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        check("reset_mid_pkt_outputs", {wr_en_2, wr_en_1, wr_en_0, suspend_data_in, err, vld_chan_2, vld_chan_1, vld_chan_0}, 8'h00);
        tick();
        reset = 1'b0;
        packet_valid = 1'b0;
        tick();
        send_byte(8'h02);
        check("post_reset_header_wr", {5'd0, last_wr}, 8'h04);
        send_byte(8'h02);
        @(negedge clock);
        check("post_reset_vld", {5'd0, vld_chan_2, vld_chan_1, vld_chan_0}, 8'h04);
        tick();
        read_pulse(2, 2);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pkt_flow_ctrl
`default_nettype wire
